// File: rtl/stereo_sample_fifo_if.sv
// Handshake bundle for stereo_sample_fifo: sample write strobes, converter
// read request/response, fill level and sticky status.
// master = sample source / converter / CPU side, slave = the FIFO itself.
interface stereo_sample_fifo_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 24
);
  logic              l_data_en;
  logic              r_data_en;
  logic [DATA_W-1:0] l_data;
  logic [DATA_W-1:0] r_data;
  logic              rd_req;
  logic              dout_valid;
  logic [DATA_W-1:0] l_data_out;
  logic [DATA_W-1:0] r_data_out;
  logic [ADDR_W:0]   level;
  logic              clr_status;
  logic [2:0]        status;

  modport master (
    output l_data_en, r_data_en, l_data, r_data, rd_req, clr_status,
    input  dout_valid, l_data_out, r_data_out, level, status
  );

  modport slave (
    input  l_data_en, r_data_en, l_data, r_data, rd_req, clr_status,
    output dout_valid, l_data_out, r_data_out, level, status
  );
endinterface

// File: rtl/stereo_sample_fifo.sv
// stereo_sample_fifo: pairs left/right sample strobes into stereo frames,
// buffers them in a circular FIFO and returns one frame per converter
// request. Underflow, overflow and pairing errors raise sticky status bits.
//
// Build option: define UNDERFLOW_HOLD_EN to repeat the last successfully
// read frame on underflow; otherwise an underflow read outputs silence (0).
module stereo_sample_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  stereo_sample_fifo_if.slave  bus
);
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int FRAME_W = 2 * DATA_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  localparam int ST_UNDERFLOW = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_PAIR_ERR  = 2;

  // NOTE: frame storage has no reset; pointers and level define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  logic [FRAME_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0]  l_hold;
  logic               l_pending;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    level_q;
  logic               dout_valid_q;
  logic [DATA_W-1:0]  l_out_q;
  logic [DATA_W-1:0]  r_out_q;
  logic [2:0]         status_q;

  logic               frame_wr;
  logic [FRAME_W-1:0] frame_data;
  logic               pair_err_set;
  logic               empty;
  logic               full;
  logic               rd_accept;
  logic               wr_accept;
  logic               overflow_set;
  logic               underflow_set;

  // Decode the strobes into a frame write request and pairing errors.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    frame_wr     = 1'b0;
    frame_data   = {l_hold, bus.r_data};
    pair_err_set = 1'b0;
    if (bus.l_data_en && bus.r_data_en) begin
      frame_wr   = 1'b1;
      frame_data = {bus.l_data, bus.r_data};
    end else if (bus.l_data_en) begin
      pair_err_set = l_pending;
    end else if (bus.r_data_en) begin
      frame_wr     = l_pending;
      pair_err_set = !l_pending;
    end
  end

  // Acceptance: a read frees a slot in the same cycle, so a full FIFO
  // still takes a write when a read is accepted alongside it.
  assign empty         = (level_q == '0);
  assign full          = (level_q == FULL_LEVEL);
  assign rd_accept     = run && bus.rd_req && !empty;
  assign wr_accept     = run && frame_wr && (!full || rd_accept);
  assign overflow_set  = run && frame_wr && !wr_accept;
  assign underflow_set = run && bus.rd_req && empty;

  // Pairing register: latest left sample waiting for its right partner.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      l_hold    <= '0;
      l_pending <= 1'b0;
    end else if (bus.l_data_en && bus.r_data_en) begin
      l_pending <= 1'b0;
    end else if (bus.l_data_en) begin
      l_hold    <= bus.l_data;
      l_pending <= 1'b1;
    end else if (bus.r_data_en) begin
      l_pending <= 1'b0;
    end
  end

  // Frame memory write port.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem[wr_ptr] <= frame_data;
    end
  end

  // Pointers and level counter; run low holds the FIFO flushed.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Read response: one-cycle valid strobe; data held until the next one.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      dout_valid_q <= 1'b0;
      l_out_q      <= '0;
      r_out_q      <= '0;
    end else begin
      dout_valid_q <= bus.rd_req;
      if (rd_accept) begin
        {l_out_q, r_out_q} <= mem[rd_ptr];
      end else if (bus.rd_req) begin
`ifdef UNDERFLOW_HOLD_EN
        l_out_q <= l_out_q;
        r_out_q <= r_out_q;
`else
        l_out_q <= '0;
        r_out_q <= '0;
`endif
      end
    end
  end

  // Sticky status: a set event in the same cycle as clr_status wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
    end else begin
      status_q <= (bus.clr_status ? 3'b000 : status_q)
                | ({2'b00, underflow_set}                        << ST_UNDERFLOW)
                | ({2'b00, overflow_set}                         << ST_OVERFLOW)
                | ({2'b00, (run && pair_err_set)}                << ST_PAIR_ERR);
    end
  end

  assign bus.dout_valid = dout_valid_q;
  assign bus.l_data_out = l_out_q;
  assign bus.r_data_out = r_out_q;
  assign bus.level      = level_q;
  assign bus.status     = status_q;
endmodule

// File: tb/tb_stereo_sample_fifo.sv
// Self-checking bench for stereo_sample_fifo: directed scenarios followed
// by a randomized run, all against a queue-based reference model.
module tb_stereo_sample_fifo;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic reset;
  logic run;

  stereo_sample_fifo_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  stereo_sample_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: a queue of {L,R} frames plus pairing/status.
  logic [47:0] q [$];
  bit          m_pend;
  logic [23:0] m_hold;
  logic [2:0]  m_status;
  logic        m_valid;
  logic [23:0] m_l;
  logic [23:0] m_r;

  task automatic model_step(input logic le, input logic re,
                            input logic [23:0] ld, input logic [23:0] rdat,
                            input logic rq, input logic clr,
                            input logic rst, input logic rn);
    logic [47:0] f;
    bit have;
    bit perr, ovf, unf;
    int pre;
    if (rst) begin
      q.delete(); m_pend = 0; m_hold = '0; m_status = '0;
      m_valid = 0; m_l = '0; m_r = '0;
      return;
    end
    if (!rn) begin
      q.delete(); m_pend = 0; m_valid = 0; m_l = '0; m_r = '0;
      if (clr) m_status = '0;
      return;
    end
    have = 0; perr = 0; ovf = 0; unf = 0; f = '0;
    if (le && re) begin
      have = 1; f = {ld, rdat}; m_pend = 0;
    end else if (le) begin
      if (m_pend) perr = 1;
      m_hold = ld; m_pend = 1;
    end else if (re) begin
      if (m_pend) begin have = 1; f = {m_hold, rdat}; m_pend = 0; end
      else perr = 1;
    end
    pre = q.size();
    m_valid = rq;
    if (rq) begin
      if (pre > 0) begin
        {m_l, m_r} = q.pop_front();
      end else begin
        unf = 1;
`ifndef UNDERFLOW_HOLD_EN
        m_l = '0; m_r = '0;
`endif
      end
    end
    if (have) begin
      if (pre < DEPTH || (rq && pre > 0)) q.push_back(f);
      else ovf = 1;
    end
    if (clr) m_status = '0;
    m_status = m_status | {perr, ovf, unf};
  endtask

  // One clock: drive inputs, advance the model, settle at the falling edge.
  task automatic tick(input logic le, input logic re,
                      input logic [23:0] ld, input logic [23:0] rdat,
                      input logic rq, input logic clr = 1'b0,
                      input logic rst = 1'b0, input logic rn = 1'b1);
    bus.l_data_en  = le;
    bus.r_data_en  = re;
    bus.l_data     = ld;
    bus.r_data     = rdat;
    bus.rd_req     = rq;
    bus.clr_status = clr;
    reset          = rst;
    run            = rn;
    @(posedge clk);
    model_step(le, re, ld, rdat, rq, clr, rst, rn);
    @(negedge clk);
  endtask

  task automatic idle();       tick(0, 0, '0, '0, 0); endtask
  task automatic rd();         tick(0, 0, '0, '0, 1); endtask
  task automatic clr();        tick(0, 0, '0, '0, 0, 1); endtask
  task automatic flush();      tick(0, 0, '0, '0, 0, 0, 0, 0); endtask
  task automatic wr_frame(input logic [23:0] l, input logic [23:0] r);
    tick(1, 1, l, r, 0);
  endtask

  task automatic test_reset();
    tick(0, 0, '0, '0, 0, 0, 1, 0);
    tick(0, 0, '0, '0, 0, 0, 1, 1);
    n_checks++;
    if ({bus.dout_valid, bus.level, bus.status, bus.l_data_out, bus.r_data_out} !== '0)
      $display("FAIL reset_outputs got v=%b lvl=%0d st=%b l=%h r=%h want all 0",
               bus.dout_valid, bus.level, bus.status, bus.l_data_out, bus.r_data_out);
    else n_pass++;
  endtask

  task automatic test_paired();
    tick(1, 0, 24'h123456, '0, 0);
    repeat (4) idle();
    tick(0, 1, '0, 24'hABCDEF, 0);
    n_checks++;
    if (bus.level !== 5'd1) $display("FAIL paired_level got %0d want 1", bus.level);
    else n_pass++;
    rd();
    n_checks++;
    if ({bus.dout_valid, bus.l_data_out, bus.r_data_out, bus.level} !== {1'b1, 24'h123456, 24'hABCDEF, 5'd0})
      $display("FAIL paired_read got v=%b l=%h r=%h lvl=%0d want v=1 l=123456 r=abcdef lvl=0",
               bus.dout_valid, bus.l_data_out, bus.r_data_out, bus.level);
    else n_pass++;
    idle();
    n_checks++;
    if (bus.dout_valid !== 1'b0) $display("FAIL paired_valid_pulse got %b want 0", bus.dout_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    clr();
    for (int i = 1; i <= DEPTH; i++) wr_frame(24'(i), 24'(i));
    n_checks++;
    if ({bus.level, bus.status} !== {5'd16, 3'b000})
      $display("FAIL ovf_fill got lvl=%0d st=%b want lvl=16 st=000", bus.level, bus.status);
    else n_pass++;
    wr_frame(24'd17, 24'd17);
    n_checks++;
    if ({bus.level, bus.status} !== {5'd16, 3'b010})
      $display("FAIL ovf_17th got lvl=%0d st=%b want lvl=16 st=010", bus.level, bus.status);
    else n_pass++;
    for (int i = 1; i <= DEPTH; i++) begin
      rd();
      n_checks++;
      if ({bus.dout_valid, bus.l_data_out, bus.r_data_out} !== {1'b1, 24'(i), 24'(i)})
        $display("FAIL ovf_read%0d got v=%b l=%h r=%h want v=1 l=r=%h",
                 i, bus.dout_valid, bus.l_data_out, bus.r_data_out, 24'(i));
      else n_pass++;
      idle();
    end
    n_checks++;
    if (bus.level !== 5'd0) $display("FAIL ovf_drained got %0d want 0", bus.level);
    else n_pass++;
  endtask

  task automatic test_underflow();
    logic [47:0] want;
    flush(); clr();
    wr_frame(24'h000111, 24'h000222);
    rd();
    idle();
    n_checks++;
    if (bus.status[0] !== 1'b0) $display("FAIL unf_before got %b want 0", bus.status[0]);
    else n_pass++;
    rd();
`ifdef UNDERFLOW_HOLD_EN
    want = {24'h000111, 24'h000222};
`else
    want = '0;
`endif
    n_checks++;
    if ({bus.dout_valid, bus.status[0], bus.l_data_out, bus.r_data_out} !== {1'b1, 1'b1, want})
      $display("FAIL unf_read got v=%b unf=%b l=%h r=%h want v=1 unf=1 data=%h",
               bus.dout_valid, bus.status[0], bus.l_data_out, bus.r_data_out, want);
    else n_pass++;
    // Write into empty FIFO alongside a read: not bypassed, stored instead.
    idle();
    tick(1, 1, 24'h0000AA, 24'h0000BB, 1);
    n_checks++;
    if ({bus.dout_valid, bus.level, bus.l_data_out, bus.r_data_out} !== {1'b1, 5'd1, want})
      $display("FAIL unf_nobypass got v=%b lvl=%0d l=%h r=%h want v=1 lvl=1 data=%h",
               bus.dout_valid, bus.level, bus.l_data_out, bus.r_data_out, want);
    else n_pass++;
    idle();
  endtask

  task automatic test_pair_err();
    flush(); clr();
    tick(0, 1, '0, 24'h000005, 0);
    n_checks++;
    if ({bus.status, bus.level} !== {3'b100, 5'd0})
      $display("FAIL perr_lone_r got st=%b lvl=%0d want st=100 lvl=0", bus.status, bus.level);
    else n_pass++;
    clr();
    n_checks++;
    if (bus.status !== 3'b000) $display("FAIL perr_clear got %b want 000", bus.status);
    else n_pass++;
    tick(1, 0, 24'h00000A, '0, 0);
    tick(1, 0, 24'h00000B, '0, 0);
    tick(0, 1, '0, 24'h00000C, 0);
    n_checks++;
    if ({bus.status, bus.level} !== {3'b100, 5'd1})
      $display("FAIL perr_double_l got st=%b lvl=%0d want st=100 lvl=1", bus.status, bus.level);
    else n_pass++;
    rd();
    n_checks++;
    if ({bus.l_data_out, bus.r_data_out} !== {24'h00000B, 24'h00000C})
      $display("FAIL perr_frame got l=%h r=%h want l=00000b r=00000c", bus.l_data_out, bus.r_data_out);
    else n_pass++;
    clr();
    // clr_status together with a new error: the set wins.
    tick(0, 1, '0, 24'h000001, 0, 1);
    n_checks++;
    if (bus.status !== 3'b100) $display("FAIL perr_set_wins got %b want 100", bus.status);
    else n_pass++;
    clr();
  endtask

  task automatic test_full_rw();
    flush(); clr();
    for (int i = 0; i < DEPTH; i++) wr_frame(24'(i + 32), 24'(i + 64));
    tick(1, 1, 24'hAAAAAA, 24'hBBBBBB, 1);
    n_checks++;
    if ({bus.level, bus.status[1], bus.dout_valid, bus.l_data_out, bus.r_data_out}
        !== {5'd16, 1'b0, 1'b1, 24'd32, 24'd64})
      $display("FAIL full_rw got lvl=%0d ovf=%b v=%b l=%h r=%h want lvl=16 ovf=0 v=1 l=20 r=40",
               bus.level, bus.status[1], bus.dout_valid, bus.l_data_out, bus.r_data_out);
    else n_pass++;
    idle();
  endtask

  task automatic test_run();
    flush(); clr();
    for (int i = 0; i < 5; i++) wr_frame(24'(i + 1), 24'(i + 1));
    n_checks++;
    if (bus.level !== 5'd5) $display("FAIL run_level5 got %0d want 5", bus.level);
    else n_pass++;
    tick(0, 0, '0, '0, 0, 0, 0, 0);
    n_checks++;
    if (bus.level !== 5'd0) $display("FAIL run_flush got %0d want 0", bus.level);
    else n_pass++;
    tick(1, 1, 24'h777777, 24'h777777, 1, 0, 0, 0);
    n_checks++;
    if ({bus.dout_valid, bus.level, bus.l_data_out, bus.r_data_out} !== '0)
      $display("FAIL run_ignored got v=%b lvl=%0d l=%h r=%h want all 0",
               bus.dout_valid, bus.level, bus.l_data_out, bus.r_data_out);
    else n_pass++;
    wr_frame(24'h0000C1, 24'h0000C2);
    n_checks++;
    if (bus.level !== 5'd1) $display("FAIL run_rise_write got %0d want 1", bus.level);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    wr_frame(24'h00F00D, 24'h00BEEF);
    tick(0, 0, '0, '0, 1, 0, 1, 1);
    n_checks++;
    if ({bus.dout_valid, bus.level, bus.status, bus.l_data_out, bus.r_data_out} !== '0)
      $display("FAIL reset_mid_read got v=%b lvl=%0d st=%b l=%h r=%h want all 0",
               bus.dout_valid, bus.level, bus.status, bus.l_data_out, bus.r_data_out);
    else n_pass++;
    wr_frame(24'h000123, 24'h000456);
    rd();
    tick(0, 0, '0, '0, 0, 0, 1, 1);
    n_checks++;
    if ({bus.dout_valid, bus.level, bus.l_data_out, bus.r_data_out} !== '0)
      $display("FAIL reset_after_read got v=%b lvl=%0d l=%h r=%h want all 0",
               bus.dout_valid, bus.level, bus.l_data_out, bus.r_data_out);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [56:0] got, want;
    bit prev_rd;
    logic le, re, rq, cl, rn;
    prev_rd = 0;
    for (int c = 0; c < 600; c++) begin
      le = ($urandom_range(99) < 35);
      re = ($urandom_range(99) < 35);
      rq = !prev_rd && ($urandom_range(99) < 40);
      cl = ($urandom_range(99) < 4);
      rn = ($urandom_range(99) >= 2);
      prev_rd = rq;
      tick(le, re, 24'($urandom), 24'($urandom), rq, cl, 1'b0, rn);
      got  = {bus.dout_valid, bus.level, bus.status, bus.l_data_out, bus.r_data_out};
      want = {m_valid, 5'(q.size()), m_status, m_l, m_r};
      n_checks++;
      if (got !== want) $display("FAIL random_c%0d got %h want %h", c, got, want);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    bus.l_data_en  = 1'b0;
    bus.r_data_en  = 1'b0;
    bus.l_data     = '0;
    bus.r_data     = '0;
    bus.rd_req     = 1'b0;
    bus.clr_status = 1'b0;
    @(negedge clk);
    test_reset();
    test_paired();
    test_overflow();
    test_underflow();
    test_pair_err();
    test_full_rw();
    test_run();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
